// File: rtl/id_inst_buffer_if.sv
// Fetch/decode bundle for the ID-stage instruction buffer.
// Master drives fetch offers, pops and flush; slave is the buffer itself.
interface id_inst_buffer_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]        in_num;
  logic [DATA_W-1:0] in_data0;
  logic [DATA_W-1:0] in_data1;
  logic              in_ready;
  logic [1:0]        out_num;
  logic [DATA_W-1:0] out_data0;
  logic [DATA_W-1:0] out_data1;
  logic [1:0]        out_pop;
  logic              flush;
  logic              flush_keep_head;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              overflow_err;

  modport master (
    output in_num, in_data0, in_data1, out_pop, flush, flush_keep_head,
    input  in_ready, out_num, out_data0, out_data1, count, empty, full, overflow_err
  );

  modport slave (
    input  in_num, in_data0, in_data1, out_pop, flush, flush_keep_head,
    output in_ready, out_num, out_data0, out_data1, count, empty, full, overflow_err
  );
endinterface

// File: rtl/id_inst_buffer.sv
// Dual-in / dual-out circular instruction buffer between fetch and decode,
// with branch/exception flush that can keep the delay-slot entry.
module id_inst_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  id_inst_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [AW-1:0] ONE_A     = AW'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              we;

  logic              in_ready;
  logic [1:0]        out_num;
  logic [1:0]        push_n, push_e, pop_e;
  logic [AW-1:0]     pop_a, push_a, r_ptr;
  logic [CW-1:0]     pop_c, push_c;

  // Status depends on registered count only, so pops never open in_ready early.
  assign in_ready = (count_q <= READY_MAX);
  assign out_num  = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];

  assign push_n = (bus.in_num == 2'd3) ? 2'd2 : bus.in_num;
  assign push_e = in_ready ? push_n : 2'd0;
  assign pop_e  = (bus.out_pop > out_num) ? out_num : bus.out_pop;

  assign pop_a  = {{(AW-2){1'b0}}, pop_e};
  assign push_a = {{(AW-2){1'b0}}, push_e};
  assign pop_c  = {{(CW-2){1'b0}}, pop_e};
  assign push_c = {{(CW-2){1'b0}}, push_e};
  assign r_ptr  = rd_ptr_q + pop_a;

  always_comb begin
    rd_ptr_d = r_ptr;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    we       = 1'b0;
    if (bus.flush) begin
      if (bus.flush_keep_head && (count_q > pop_c)) begin
        wr_ptr_d = r_ptr + ONE_A;
        count_d  = CW'(1);
      end else begin
        wr_ptr_d = r_ptr;
        count_d  = '0;
      end
    end else begin
      wr_ptr_d = wr_ptr_q + push_a;
      count_d  = count_q + push_c - pop_c;
      we       = (push_e != 2'd0);
      if ((push_n != 2'd0) && !in_ready) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (rst && we) begin
      mem_q[wr_ptr_q] <= bus.in_data0;
      if (push_e == 2'd2) mem_q[wr_ptr_q + ONE_A] <= bus.in_data1;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_num      = out_num;
  assign bus.out_data0    = (out_num != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign bus.out_data1    = (out_num == 2'd2) ? mem_q[rd_ptr_q + ONE_A] : '0;
  assign bus.count        = count_q;
  assign bus.empty        = (count_q == '0);
  assign bus.full         = (count_q == FULL_CNT);
  assign bus.overflow_err = ovf_q;
endmodule
